// File: rtl/wb_pkg.sv
// =============================================================================
// wb_pkg - shared constants and helpers for the writeback arbiter | rev 1.0
// =============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;
    localparam int NREQ      = 3;

    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_LD  = 2'd1;
    localparam logic [1:0] REQ_MDU = 2'd2;

    typedef logic [1:0] ptr_t;

    // Priority moves to the requester just after the one that won.
    function automatic ptr_t next_ptr(input logic [NREQ-1:0] gnt);
        ptr_t p;
        p = REQ_ALU;
        if (gnt[REQ_ALU]) begin
            p = REQ_LD;
        end else if (gnt[REQ_LD]) begin
            p = REQ_MDU;
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb3.sv
// =============================================================================
// rr_arb3 - combinational three-way round-robin grant search | rev 1.0
// =============================================================================
`default_nettype none

module rr_arb3
    import wb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  ptr_t            ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (en) begin
            case (ptr)
                REQ_LD: begin
                    if (req[REQ_LD])       gnt = 3'b010;
                    else if (req[REQ_MDU]) gnt = 3'b100;
                    else if (req[REQ_ALU]) gnt = 3'b001;
                end
                REQ_MDU: begin
                    if (req[REQ_MDU])      gnt = 3'b100;
                    else if (req[REQ_ALU]) gnt = 3'b001;
                    else if (req[REQ_LD])  gnt = 3'b010;
                end
                default: begin
                    if (req[REQ_ALU])      gnt = 3'b001;
                    else if (req[REQ_LD])  gnt = 3'b010;
                    else if (req[REQ_MDU]) gnt = 3'b100;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// =============================================================================
// wb_arbiter - round-robin writeback arbiter for the register file ports | rev 1.0
// =============================================================================
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_lo,
    input  logic [DATA_W-1:0] mdu_hi,
    output logic              mdu_ready,
    output logic [ADDR_W-1:0] WA1,
    output logic [DATA_W-1:0] WD1,
    output logic              RegWrite,
    output logic [DATA_W-1:0] R0D,
    output logic              R0W,
    output logic [15:0]       wb_count
);

    ptr_t            r_ptr;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic            w_en;
    logic            w_mdu_gp;

    // Gating with rst keeps every ready low while reset is held.
    assign w_en  = wb_en & rst;
    assign w_req = {mdu_valid, ld_valid, alu_valid};

    rr_arb3 u_rr_arb3 (
        .req (w_req),
        .ptr (r_ptr),
        .en  (w_en),
        .gnt (w_gnt)
    );

    assign alu_ready = w_gnt[REQ_ALU];
    assign ld_ready  = w_gnt[REQ_LD];
    assign mdu_ready = w_gnt[REQ_MDU];

    // An MDU result aimed at R0 goes only through the R0 port.
    assign w_mdu_gp = w_gnt[REQ_MDU] & (mdu_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= REQ_ALU;
            WA1      <= '0;
            WD1      <= '0;
            RegWrite <= 1'b0;
            R0D      <= '0;
            R0W      <= 1'b0;
            wb_count <= 16'd0;
        end else begin
            RegWrite <= w_gnt[REQ_ALU] | w_gnt[REQ_LD] | w_mdu_gp;
            R0W      <= w_gnt[REQ_MDU];
            if (|w_gnt) begin
                r_ptr    <= next_ptr(w_gnt);
                wb_count <= wb_count + 16'd1;
            end
            if (w_gnt[REQ_ALU]) begin
                WA1 <= alu_rd;
                WD1 <= alu_data;
            end else if (w_gnt[REQ_LD]) begin
                WA1 <= ld_rd;
                WD1 <= ld_data;
            end else if (w_mdu_gp) begin
                WA1 <= mdu_rd;
                WD1 <= mdu_lo;
            end
            if (w_gnt[REQ_MDU]) begin
                R0D <= mdu_hi;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// =============================================================================
// tb_wb_arbiter - directed and randomized self-checking bench for wb_arbiter | rev 1.0
// =============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic        alu_valid, ld_valid, mdu_valid;
    logic [3:0]  alu_rd, ld_rd, mdu_rd;
    logic [15:0] alu_data, ld_data, mdu_lo, mdu_hi;
    logic        alu_ready, ld_ready, mdu_ready;
    logic [3:0]  WA1;
    logic [15:0] WD1, R0D;
    logic        RegWrite, R0W;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk(clk), .rst(rst), .wb_en(wb_en),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_lo(mdu_lo), .mdu_hi(mdu_hi),
        .mdu_ready(mdu_ready),
        .WA1(WA1), .WD1(WD1), .RegWrite(RegWrite), .R0D(R0D), .R0W(R0W),
        .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority scan starting at the pointer, mod 3.
    function automatic int model_grant(input logic [2:0] v, input int p, input logic en);
        int idx;
        if (!en) return -1;
        for (int k = 0; k < 3; k++) begin
            idx = (p + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    int          m_ptr      = 0;
    int          m_g;
    int          m_last_gnt = -1;
    logic        m_rw       = 1'b0;
    logic        m_r0w      = 1'b0;
    logic [3:0]  m_wa       = '0;
    logic [15:0] m_wd       = '0;
    logic [15:0] m_r0d      = '0;
    logic [15:0] m_cnt      = '0;
    logic        m_wrap     = 1'b0;

    always_comb m_g = model_grant({mdu_valid, ld_valid, alu_valid}, m_ptr, wb_en && rst);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr <= 0; m_rw <= 1'b0; m_r0w <= 1'b0; m_wa <= '0; m_wd <= '0;
            m_r0d <= '0; m_cnt <= '0; m_last_gnt <= -1;
        end else begin
            m_last_gnt <= m_g;
            m_rw  <= (m_g == 0) || (m_g == 1) || (m_g == 2 && mdu_rd != 4'd0);
            m_r0w <= (m_g == 2);
            if (m_g == 0) begin m_wa <= alu_rd; m_wd <= alu_data; end
            if (m_g == 1) begin m_wa <= ld_rd;  m_wd <= ld_data;  end
            if (m_g == 2) begin
                m_r0d <= mdu_hi;
                if (mdu_rd != 4'd0) begin m_wa <= mdu_rd; m_wd <= mdu_lo; end
            end
            if (m_g >= 0) begin
                m_ptr <= (m_g + 1) % 3;
                m_cnt <= m_cnt + 16'd1;
                if (m_cnt == 16'hFFFF) m_wrap <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("alu_ready", alu_ready, m_g == 0);
        check("ld_ready",  ld_ready,  m_g == 1);
        check("mdu_ready", mdu_ready, m_g == 2);
        check("RegWrite",  RegWrite,  m_rw);
        check("R0W",       R0W,       m_r0w);
        check("WA1",       WA1,       m_wa);
        check("WD1",       WD1,       m_wd);
        check("R0D",       R0D,       m_r0d);
        check("wb_count",  wb_count,  m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] rr_act;

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst = 1'b0; wb_en = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 16'h4444;
        ld_valid  = 1'b1; ld_rd  = 4'd7; ld_data  = 16'h7777;
        mdu_valid = 1'b1; mdu_rd = 4'd5; mdu_lo   = 16'h5555; mdu_hi = 16'h0001;

        repeat (3) step();
        @(negedge clk);
        check("rst_readys", {mdu_ready, ld_ready, alu_ready}, 3'b000);
        check("rst_strobes", {RegWrite, R0W}, 2'b00);
        check("rst_count", wb_count, 16'd0);

        step(); rst = 1'b1;
        @(negedge clk);
        check("first_grant_alu", {mdu_ready, ld_ready, alu_ready}, 3'b001);
        step(); alu_valid = 1'b0; ld_valid = 1'b0; mdu_valid = 1'b0;
        @(negedge clk);
        check("alu_write", {RegWrite, R0W, WA1, WD1}, {1'b1, 1'b0, 4'd4, 16'h4444});
        check("alu_count", wb_count, 16'd1);

        step(); mdu_valid = 1'b1;
        @(negedge clk);
        check("mdu_ready", mdu_ready, 1'b1);
        step(); mdu_valid = 1'b0;
        @(negedge clk);
        check("mdu_dual", {RegWrite, WA1, WD1, R0W, R0D}, {1'b1, 4'd5, 16'h5555, 1'b1, 16'h0001});

        step(); mdu_valid = 1'b1; mdu_rd = 4'd0; mdu_lo = 16'hAAAA; mdu_hi = 16'h1234;
        step(); mdu_valid = 1'b0;
        @(negedge clk);
        check("r0_conflict", {RegWrite, R0W, R0D, WD1}, {1'b0, 1'b1, 16'h1234, 16'h5555});
        check("r0_count", wb_count, 16'd3);

        step(); alu_valid = 1'b1; ld_valid = 1'b1; mdu_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rr_act = {mdu_ready, ld_ready, alu_ready};
            check("rr_order", rr_act, rr_exp[i]);
            step();
        end
        alu_valid = 1'b0; ld_valid = 1'b0; mdu_valid = 1'b0;

        ld_valid = 1'b1; wb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ld_ready", ld_ready, 1'b0);
            step();
        end
        wb_en = 1'b1;
        @(negedge clk);
        check("unstall_ld_ready", ld_ready, 1'b1);
        step(); ld_valid = 1'b0;
        @(negedge clk);
        check("ld_write", {RegWrite, WA1, WD1}, {1'b1, 4'd7, 16'h7777});
        check("ld_count", wb_count, 16'd10);

        step(); alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h9999;
        @(negedge clk);
        check("pre_rst_grant", alu_ready, 1'b1);
        step(); alu_valid = 1'b0; rst = 1'b0;
        #1;
        check("rst_drop", RegWrite, 1'b0);
        step(); rst = 1'b1;
        @(negedge clk);
        check("post_rst_no_pulse", {RegWrite, R0W}, 2'b00);
        check("post_rst_count", wb_count, 16'd0);

        for (int c = 0; c < 72000; c++) begin
            step();
            wb_en = ($urandom_range(15, 0) != 0);
            if (!alu_valid || m_last_gnt == 0) begin
                alu_valid = ($urandom_range(15, 0) != 0);
                alu_rd = 4'($urandom_range(15, 0)); alu_data = 16'($urandom);
            end
            if (!ld_valid || m_last_gnt == 1) begin
                ld_valid = ($urandom_range(15, 0) != 0);
                ld_rd = 4'($urandom_range(15, 0)); ld_data = 16'($urandom);
            end
            if (!mdu_valid || m_last_gnt == 2) begin
                mdu_valid = ($urandom_range(15, 0) != 0);
                mdu_rd = 4'($urandom_range(15, 0));
                mdu_lo = 16'($urandom); mdu_hi = 16'($urandom);
            end
        end
        @(negedge clk);
        check("count_wrap_seen", m_wrap, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the register file's single general write port (WA1/WD1/RegWrite) and its dedicated R0 port (R0D/R0W) among three writeback sources: ALU, load unit, and multiply/divide unit (MDU). It sits between the execute/memory stages and the 16x16 register file. It grants one requester per cycle, round-robin, using a valid/ready handshake, and drives registered write strobes into the register file.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_en  in  1  global writeback enable; 0 = no grants (pipeline stall)
- alu_valid  in  1  ALU write request
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid / ld_rd / ld_data / ld_ready  as ALU, for the load unit
- mdu_valid  in  1  MDU write request
- mdu_rd  in  ADDR_W  destination for the low half
- mdu_lo  in  DATA_W  low half, written to mdu_rd
- mdu_hi  in  DATA_W  high half, written to R0
- mdu_ready  out  1  MDU request accepted
- WA1  out  ADDR_W  register file write address
- WD1  out  DATA_W  register file write data
- RegWrite  out  1  general write strobe
- R0D  out  DATA_W  R0 write data
- R0W  out  1  R0 write strobe
- wb_count  out  16  accepted writebacks since reset, wraps at 0xFFFF -> 0

## Operation
- Requester indices: 0 = ALU, 1 = LD, 2 = MDU.
- Round-robin pointer `ptr` (2 bits, legal values 0..2) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2 (mod 3).
- Grant: the first valid requester in search order, only when wb_en=1. Exactly one *_ready goes high, or none.
- ready is combinational from valid, ptr and wb_en. ready never asserts without the matching valid.
- On a grant to index g, ptr <= (g+1) mod 3 at the clock edge. With no grant, ptr holds.
- Accepted ALU/LD request: RegWrite=1, WA1=rd, WD1=data. R0W=0.
- Accepted MDU request: RegWrite=1, WA1=mdu_rd, WD1=mdu_lo, R0W=1, R0D=mdu_hi.
- R0 conflict: if an MDU request has mdu_rd==0, RegWrite is forced to 0 and only R0W=1 with mdu_hi is issued. The R0 port always wins, and the low half is discarded.
- ALU/LD writes with rd==0 go through the general port normally.
- wb_count increments by 1 per accepted request.

## Timing
- Reset (rst=0, asynchronous): RegWrite=0, R0W=0, WA1=0, WD1=0, R0D=0, wb_count=0, ptr=0. All *_ready outputs read 0 while rst=0.
- Latency is 1 cycle. A request accepted at edge N drives the write outputs throughout cycle N+1, so the register file captures them at edge N+1.
- Strobes are single-cycle. With no grant at edge N, RegWrite=R0W=0 in cycle N+1. WA1/WD1/R0D hold their last values.
- A requester must hold valid/rd/data stable until it sees ready at an edge.
- Back-to-back grants are allowed every cycle, for a throughput of 1 write per cycle.
- wb_en=0 blocks new grants. A write already registered from the previous edge still completes.
- Reset asserted mid-operation: any registered pending write is dropped, and no strobe appears after reset deasserts until a new grant.
- Boundary: ptr never takes value 3. A count of 0xFFFF followed by one accept gives 0x0000.

## Structure
- Shared package `wb_pkg`:
  - requester index constants REQ_ALU=0, REQ_LD=1, REQ_MDU=2
  - NREQ=3
  - DATA_W/ADDR_W defaults
- Sub-module `rr_arb3`: inputs req[2:0], ptr, en; output one-hot gnt[2:0]. It is purely combinational and holds the pointer-rotation search.
- The top level contains the ptr register, the output registers, the R0 conflict logic and wb_count.

## Test plan
- Reset: hold rst=0 with all valids=1 -> all readys 0, RegWrite=R0W=0, wb_count=0. Release rst -> ALU is granted first (ptr=0).
- Single ALU write: alu_valid=1, rd=4, data=0x4444 -> alu_ready in cycle N. Next cycle RegWrite=1, WA1=4, WD1=0x4444, R0W=0. wb_count=1.
- Round-robin: all three valid continuously -> grant order ALU, LD, MDU, ALU, … Each requester gets exactly 1 grant per 3 cycles.
- MDU dual write: mdu_rd=5, lo=0x5555, hi=0x0001 -> RegWrite=1, WA1=5, WD1=0x5555 and R0W=1, R0D=0x0001, both in the same cycle.
- R0 conflict: mdu_rd=0, lo=0xAAAA, hi=0x1234 -> RegWrite=0, R0W=1, R0D=0x1234.
- Stall and reset mid-flight:
  - LD valid with wb_en=0 for 3 cycles -> no ld_ready. Set wb_en=1 -> granted.
  - Assert rst in the cycle after a grant -> no RegWrite pulse appears.
